fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch.sv | 152 +++++++++++++++
 tb/tb_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_if
// Brief  : Instruction-memory request/acknowledge bus between fetch and imem.
// Rev    : 1.0  initial release
// ============================================================================
interface fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );
endinterface
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module : fetch
// Brief  : Instruction fetch FSM (IDLE/WAIT/DONE) with PC, redirect and
//          optional WAIT timeout enabled by macro FETCH_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_if.master       imem,
  input  logic [2:0]    stage_i,
  input  logic          pc_load_i,
  input  logic [31:0]   pc_target_i,
  output logic [31:0]   ir_o,
  output logic [31:0]   pc_o,
  output logic          ir_valid_o,
  output logic          fetch_done_o,
  output logic          misaligned_o,
  output logic          fault_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic [31:0] r_ir;
  logic [31:0] r_pc_o;
  logic        r_ir_valid;
  logic        r_done;
  logic        r_misal;
  logic        r_pend_valid;
  logic [31:0] r_pend_pc;

  logic        w_redir_ok;
  logic        w_redir_bad;
  logic        w_start;
  logic        w_fault;
  logic [31:0] w_next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_fault;
  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  always_comb begin
    w_redir_ok  = pc_load_i && (pc_target_i[1:0] == 2'b00);
    w_redir_bad = pc_load_i && (pc_target_i[1:0] != 2'b00);
    w_start     = (r_state == S_IDLE) && (stage_i == 3'd0) && !w_fault;
    // Newest redirect wins, then a stored one, else sequential (wraps at 2^32)
    w_next_pc   = w_redir_ok   ? pc_target_i :
                  r_pend_valid ? r_pend_pc   : r_addr + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_addr       <= 32'h0;
      r_req        <= 1'b0;
      r_ir         <= c_NOP;
      r_pc_o       <= 32'h0;
      r_ir_valid   <= 1'b0;
      r_done       <= 1'b0;
      r_misal      <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_fault      <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_misal <= w_redir_bad;
      case (r_state)
        S_IDLE: begin
          if (w_redir_ok) r_pc <= pc_target_i;
          if (w_start) begin
            r_state    <= S_WAIT;
            r_req      <= 1'b1;
            r_addr     <= r_pc;
            r_ir_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
            // A redirect arriving with the launch applies after this fetch
            if (w_redir_ok) begin
              r_pend_valid <= 1'b1;
              r_pend_pc    <= pc_target_i;
            end
          end
        end
        S_WAIT: begin
          if (imem.imem_ack_i) begin
            r_state      <= S_DONE;
            r_ir         <= imem.imem_data_i;
            r_pc_o       <= r_addr;
            r_ir_valid   <= 1'b1;
            r_req        <= 1'b0;
            r_done       <= 1'b1;
            r_pc         <= w_next_pc;
            r_pend_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_fault      <= 1'b1;
            r_pend_valid <= 1'b0;
`endif
          end else begin
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
            if (w_redir_ok) begin
              r_pend_valid <= 1'b1;
              r_pend_pc    <= pc_target_i;
            end
          end
        end
        S_DONE: begin
          if (w_redir_ok) r_pc <= pc_target_i;
          if (stage_i != 3'd0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem.imem_req_o  = r_req;
  assign imem.imem_addr_o = r_addr;
  assign ir_o             = r_ir;
  assign pc_o             = r_pc_o;
  assign ir_valid_o       = r_ir_valid;
  assign fetch_done_o     = r_done;
  assign misaligned_o     = r_misal;
  assign fault_o          = w_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch
// Brief  : Directed self-checking bench for the fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch;

  logic        clk;
  logic        reset;
  logic [2:0]  stage_i;
  logic        pc_load_i;
  logic [31:0] pc_target_i;
  logic [31:0] ir_o;
  logic [31:0] pc_o;
  logic        ir_valid_o;
  logic        fetch_done_o;
  logic        misaligned_o;
  logic        fault_o;

  int tests_run;
  int tests_failed;

  fetch_if bus ();

  fetch #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (bus.master),
    .stage_i      (stage_i),
    .pc_load_i    (pc_load_i),
    .pc_target_i  (pc_target_i),
    .ir_o         (ir_o),
    .pc_o         (pc_o),
    .ir_valid_o   (ir_valid_o),
    .fetch_done_o (fetch_done_o),
    .misaligned_o (misaligned_o),
    .fault_o      (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; stage_i = 3'd0; pc_load_i = 1'b0; pc_target_i = 32'h0;
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'hFFFF_FFFF;
    tick(); tick();
    tests_run++;
    if (ir_o !== 32'h0000_0013 || pc_o !== 32'h0 || bus.imem_addr_o !== 32'h0 ||
        bus.imem_req_o !== 1'b0 || ir_valid_o !== 1'b0 || fetch_done_o !== 1'b0 ||
        misaligned_o !== 1'b0 || fault_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ir=%h pc_o=%h addr=%h req=%b v=%b done=%b mis=%b flt=%b, required ir=00000013 rest 0",
               ir_o, pc_o, bus.imem_addr_o, bus.imem_req_o, ir_valid_o, fetch_done_o, misaligned_o, fault_o);
    end
    bus.imem_ack_i = 1'b0; stage_i = 3'd1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_fetch;
    stage_i = 3'd0;
    tick();
    tests_run++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0 || fetch_done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_req: req=%b addr=%h done=%b, required 1 00000000 0",
               bus.imem_req_o, bus.imem_addr_o, fetch_done_o);
    end
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h0050_0093;
    tick();
    bus.imem_ack_i = 1'b0;
    tests_run++;
    if (fetch_done_o !== 1'b1 || ir_o !== 32'h0050_0093 || pc_o !== 32'h0 ||
        ir_valid_o !== 1'b1 || bus.imem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done: done=%b ir=%h pc_o=%h v=%b req=%b, required 1 00500093 00000000 1 0",
               fetch_done_o, ir_o, pc_o, ir_valid_o, bus.imem_req_o);
    end
    tick();
    tests_run++;
    if (fetch_done_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_hold_done: done=%b req=%b, required 0 0", fetch_done_o, bus.imem_req_o);
    end
    stage_i = 3'd1; tick();
    stage_i = 3'd0; tick();
    tests_run++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4) begin
      tests_failed++;
      $display("FAIL basic_next_pc: req=%b addr=%h, required 1 00000004", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_delayed_ack;
    int bad;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4 || fetch_done_o !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL delayed_stable: %0d unstable cycles, required 0 (req=%b addr=%h)",
               bad, bus.imem_req_o, bus.imem_addr_o);
    end
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack_i = 1'b0;
    tests_run++;
    if (fetch_done_o !== 1'b1 || ir_o !== 32'hDEAD_BEEF || pc_o !== 32'h4) begin
      tests_failed++;
      $display("FAIL delayed_done: done=%b ir=%h pc_o=%h, required 1 deadbeef 00000004",
               fetch_done_o, ir_o, pc_o);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.imem_req_o !== 1'b0 || fetch_done_o !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL delayed_no_refetch: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_redirect;
    stage_i = 3'd1; tick();
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h0000_0BAD;
    tick();
    bus.imem_ack_i = 1'b0;
    tests_run++;
    if (ir_o !== 32'hDEAD_BEEF || fetch_done_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_outside_wait: ir=%h done=%b req=%b, required deadbeef 0 0",
               ir_o, fetch_done_o, bus.imem_req_o);
    end
    stage_i = 3'd0; tick();
    pc_load_i = 1'b1; pc_target_i = 32'h0000_0100;
    tick();
    pc_load_i = 1'b0;
    tests_run++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin
      tests_failed++;
      $display("FAIL redir_inflight: req=%b addr=%h, required 1 00000008", bus.imem_req_o, bus.imem_addr_o);
    end
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h1111_1111;
    tick();
    bus.imem_ack_i = 1'b0;
    tests_run++;
    if (ir_o !== 32'h1111_1111 || pc_o !== 32'h8 || fetch_done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL redir_deliver: ir=%h pc_o=%h done=%b, required 11111111 00000008 1",
               ir_o, pc_o, fetch_done_o);
    end
    stage_i = 3'd1; tick();
    stage_i = 3'd0; tick();
    tests_run++;
    if (bus.imem_addr_o !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL redir_target: addr=%h, required 00000100", bus.imem_addr_o);
    end
    pc_load_i = 1'b1; pc_target_i = 32'h0000_0102;
    tick();
    pc_load_i = 1'b0;
    tests_run++;
    if (misaligned_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_pulse: mis=%b, required 1", misaligned_o);
    end
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h2222_2222;
    tick();
    bus.imem_ack_i = 1'b0;
    tests_run++;
    if (misaligned_o !== 1'b0 || pc_o !== 32'h100) begin
      tests_failed++;
      $display("FAIL misaligned_clear: mis=%b pc_o=%h, required 0 00000100", misaligned_o, pc_o);
    end
    stage_i = 3'd1; tick();
    stage_i = 3'd0; tick();
    tests_run++;
    if (bus.imem_addr_o !== 32'h0000_0104) begin
      tests_failed++;
      $display("FAIL misaligned_pc_kept: addr=%h, required 00000104", bus.imem_addr_o);
    end
    pc_load_i = 1'b1; pc_target_i = 32'h0000_0300; tick();
    pc_target_i = 32'h0000_0400; tick();
    pc_load_i = 1'b0;
    bus.imem_ack_i = 1'b1; tick();
    bus.imem_ack_i = 1'b0;
    stage_i = 3'd1; tick();
    stage_i = 3'd0; tick();
    tests_run++;
    if (bus.imem_addr_o !== 32'h0000_0400) begin
      tests_failed++;
      $display("FAIL redir_overwrite: addr=%h, required 00000400", bus.imem_addr_o);
    end
    bus.imem_ack_i = 1'b1; tick();
    bus.imem_ack_i = 1'b0;
    pc_load_i = 1'b1; pc_target_i = 32'h0000_0200; tick();
    pc_load_i = 1'b0;
    stage_i = 3'd1; tick();
    stage_i = 3'd0; tick();
    tests_run++;
    if (bus.imem_addr_o !== 32'h0000_0200) begin
      tests_failed++;
      $display("FAIL redir_in_done: addr=%h, required 00000200", bus.imem_addr_o);
    end
    bus.imem_ack_i = 1'b1; tick();
    bus.imem_ack_i = 1'b0;
    stage_i = 3'd1; tick();
  endtask

  task automatic test_wrap;
    pc_load_i = 1'b1; pc_target_i = 32'hFFFF_FFFC; tick();
    pc_load_i = 1'b0;
    stage_i = 3'd0; tick();
    tests_run++;
    if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_start: addr=%h, required fffffffc", bus.imem_addr_o);
    end
    bus.imem_ack_i = 1'b1; tick();
    bus.imem_ack_i = 1'b0;
    stage_i = 3'd1; tick();
    stage_i = 3'd0; tick();
    tests_run++;
    if (bus.imem_addr_o !== 32'h0000_0000 || bus.imem_req_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_next: addr=%h req=%b, required 00000000 1", bus.imem_addr_o, bus.imem_req_o);
    end
  endtask

  task automatic test_reset_mid_wait;
    reset = 1'b1; tick();
    tests_run++;
    if (bus.imem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_req: req=%b, required 0", bus.imem_req_o);
    end
    reset = 1'b0; stage_i = 3'd1;
    bus.imem_ack_i = 1'b1; bus.imem_data_i = 32'h5555_5555;
    tick();
    bus.imem_ack_i = 1'b0;
    tests_run++;
    if (ir_o !== 32'h0000_0013 || ir_valid_o !== 1'b0 || fetch_done_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_late_ack: ir=%h v=%b done=%b req=%b, required 00000013 0 0 0",
               ir_o, ir_valid_o, fetch_done_o, bus.imem_req_o);
    end
    stage_i = 3'd0; tick();
    tests_run++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_idle_restart: req=%b addr=%h, required 1 00000000", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_timeout;
    int bad;
    bad = 0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      if (fault_o !== 1'b0 || bus.imem_req_o !== 1'b1) bad++;
    end
    tick();
    tests_run++;
    if (bad != 0 || fault_o !== 1'b1 || bus.imem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_fault: early=%0d flt=%b req=%b, required 0 1 0", bad, fault_o, bus.imem_req_o);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fault_o !== 1'b1 || bus.imem_req_o !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL timeout_sticky: %0d bad cycles, required 0", bad);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fault_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL no_timeout_wait: %0d bad cycles, required 0 (flt=%b req=%b)", bad, fault_o, bus.imem_req_o);
    end
`endif
    reset = 1'b1; tick();
    reset = 1'b0; stage_i = 3'd1; tick();
    tests_run++;
    if (fault_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_reset_clear: flt=%b req=%b, required 0 0", fault_o, bus.imem_req_o);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    stage_i = 3'd1;
    pc_load_i = 1'b0;
    pc_target_i = 32'h0;
    bus.imem_ack_i = 1'b0;
    bus.imem_data_i = 32'h0;
    test_reset();
    test_basic_fetch();
    test_delayed_ack();
    test_redirect();
    test_wrap();
    test_reset_mid_wait();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
